// File: rtl/operand_fetch_pkg.sv
// Shared constants and the operand bundle handed from issue to execute.
// Imported by the scoreboard, the interface and the issue stage top.
package operand_fetch_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int OP_W     = 4;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [OP_W-1:0]     op_t;
    typedef logic [NUM_REGS-1:0] regmask_t;

    typedef struct packed {
        op_t   op;
        addr_t rd;
        logic  wr;
        data_t imm;
        data_t a;
        data_t b;
    } bundle_t;

    function automatic regmask_t onehot(addr_t idx, logic en);
        regmask_t v;
        v = '0;
        if (en) v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode, register-file, writeback and execute signals of the issue stage.
// master is the surrounding pipeline, slave is operand_fetch.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic  in_valid;
    logic  in_ready;
    op_t   in_op;
    addr_t in_rs_a;
    addr_t in_rs_b;
    addr_t in_rd;
    logic  in_wr;
    data_t in_imm;

    addr_t rf_addr_a;
    addr_t rf_addr_b;
    data_t rf_data_a;
    data_t rf_data_b;

    logic  wb_valid;
    addr_t wb_addr;
    data_t wb_data;

    logic  out_valid;
    logic  out_ready;
    op_t   out_op;
    addr_t out_rd;
    logic  out_wr;
    data_t out_imm;
    data_t out_a;
    data_t out_b;

    modport master (
        output in_valid, in_op, in_rs_a, in_rs_b, in_rd, in_wr, in_imm,
        output rf_data_a, rf_data_b,
        output wb_valid, wb_addr, wb_data,
        output out_ready,
        input  in_ready, rf_addr_a, rf_addr_b,
        input  out_valid, out_op, out_rd, out_wr, out_imm, out_a, out_b
    );

    modport slave (
        input  in_valid, in_op, in_rs_a, in_rs_b, in_rd, in_wr, in_imm,
        input  rf_data_a, rf_data_b,
        input  wb_valid, wb_addr, wb_data,
        input  out_ready,
        output in_ready, rf_addr_a, rf_addr_b,
        output out_valid, out_op, out_rd, out_wr, out_imm, out_a, out_b
    );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Pending-writeback tracker: one busy bit per register plus hazard checks.
// A same-cycle writeback clears the hazard and selects the bypass path.
module operand_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  addr_t rs_a,
    input  addr_t rs_b,
    input  addr_t rd,
    input  logic  wr,
    input  logic  set_en,
    input  logic  wb_valid,
    input  addr_t wb_addr,
    output logic  hazard_a,
    output logic  hazard_b,
    output logic  hazard_d,
    output logic  clr_a,
    output logic  clr_b
);

    regmask_t busy;
    regmask_t clr;

    assign clr = onehot(wb_addr, wb_valid);

    assign clr_a    = clr[rs_a];
    assign clr_b    = clr[rs_b];
    assign hazard_a = busy[rs_a] && !clr[rs_a];
    assign hazard_b = busy[rs_b] && !clr[rs_b];
    assign hazard_d = wr && busy[rd] && !clr[rd];

    // Set is applied after clear so a new writer survives an old writeback.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= (busy & ~clr) | onehot(rd, set_en);
    end

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: reads operands, bypasses writeback, stalls on pending
// writers and holds a one-entry bundle for execute.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);

    logic    hazard_a;
    logic    hazard_b;
    logic    hazard_d;
    logic    clr_a;
    logic    clr_b;
    logic    slot_free;
    logic    accept;
    logic    out_valid_q;
    bundle_t d;
    bundle_t q;

    operand_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .rs_a     (bus.in_rs_a),
        .rs_b     (bus.in_rs_b),
        .rd       (bus.in_rd),
        .wr       (bus.in_wr),
        .set_en   (accept && bus.in_wr),
        .wb_valid (bus.wb_valid),
        .wb_addr  (bus.wb_addr),
        .hazard_a (hazard_a),
        .hazard_b (hazard_b),
        .hazard_d (hazard_d),
        .clr_a    (clr_a),
        .clr_b    (clr_b)
    );

    assign bus.rf_addr_a = bus.in_rs_a;
    assign bus.rf_addr_b = bus.in_rs_b;

    assign slot_free    = !out_valid_q || bus.out_ready;
    assign bus.in_ready = slot_free && !hazard_a && !hazard_b && !hazard_d;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        d     = '0;
        d.op  = bus.in_op;
        d.rd  = bus.in_rd;
        d.wr  = bus.in_wr;
        d.imm = bus.in_imm;
        d.a   = clr_a ? bus.wb_data : bus.rf_data_a;
        d.b   = clr_b ? bus.wb_data : bus.rf_data_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            q           <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            q           <= d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_op    = q.op;
    assign bus.out_rd    = q.rd;
    assign bus.out_wr    = q.wr;
    assign bus.out_imm   = q.imm;
    assign bus.out_a     = q.a;
    assign bus.out_b     = q.b;

endmodule
